// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
//
// Registered driver for a bank of NUM_DIGITS active-low seven-segment digits.
// User logic presents a packed hex value and a blanking mask and strobes LOAD.
// The pair is captured into shadow registers. The display register then
// rebuilds every digit each cycle from:
//   - the shadow value and the shadow blanking mask,
//   - live leading-zero suppression,
//   - an optional prescaled per-digit blink.
// No input reaches the pins combinationally; HEX is always a flop output.
//
// Optional feature macro: HEX_DISPLAY_CTRL_BLINK_EN
//   defined   : blink prescaler present, BLINK honoured, BLINK_PHASE toggles
//   undefined : no prescaler, BLINK ignored, BLINK_PHASE tied low
//
// Parameters
//   NUM_DIGITS   number of digits driven (1..16)
//   BLINK_DIV    blink half-period in clock cycles (>= 1)
//
// Ports
//   CLOCK_50     system clock, all state on the rising edge
//   RESET        asynchronous, active-high reset
//   LOAD         capture strobe for VALUE and BLANK
//   VALUE        nibble k drives digit k, digit 0 least significant
//   BLANK        per-digit force-blank mask, captured with LOAD
//   LZ_SUPPRESS  live enable for leading-zero suppression
//   BLINK        live per-digit blink enable
//   HEX          active-low segments, bits [7k+6:7k] = digit k (bit 0 = seg a)
//   BLINK_PHASE  current blink phase, 1 = blinking digits dark
// -----------------------------------------------------------------------------
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic [NUM_DIGITS-1:0]   BLANK,
    input  logic                    LZ_SUPPRESS,
    input  logic [NUM_DIGITS-1:0]   BLINK,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    BLINK_PHASE
);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Active-low hex glyph, bit order g..a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // -------------------------------------------------------------------------
    // Shadow registers
    // -------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;

    always_comb begin
        value_d = value_q;
        blank_d = blank_q;
        if (LOAD) begin
            value_d = VALUE;
            blank_d = BLANK;
        end
    end

    // Reset leaves every digit blanked so the board powers up dark until the
    // first LOAD.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            value_q <= '0;
            blank_q <= '1;
        end else begin
            value_q <= value_d;
            blank_q <= blank_d;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero suppression
    // -------------------------------------------------------------------------
    // Walk from the most significant digit down. Once any nonzero nibble has
    // been seen, no lower digit is suppressed. The shadow blank mask is
    // deliberately not consulted: a blanked digit with a nonzero nibble still
    // ends the run of leading zeros. Digit 0 always stays lit.
    logic [NUM_DIGITS-1:0] lz_mask;

    always_comb begin
        logic seen_nz;
        seen_nz = 1'b0;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (value_q[4*k +: 4] != 4'h0) begin
                seen_nz = 1'b1;
            end
            if ((k != 0) && !seen_nz && LZ_SUPPRESS) begin
                lz_mask[k] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Blink prescaler
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] blink_dark;

`ifdef HEX_DISPLAY_CTRL_BLINK_EN
    localparam int              CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // With BLINK_DIV = 1 CNT_LAST is 0, so the wrap fires every cycle and the
    // phase toggles on every edge.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_dark  = BLINK & {NUM_DIGITS{phase_q}};
    assign BLINK_PHASE = phase_q;
`else
    // Blink disabled in this build: BLINK is accepted but has no effect.
    logic unused_blink;
    assign unused_blink = ^BLINK;

    assign blink_dark  = '0;
    assign BLINK_PHASE = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Display register
    // -------------------------------------------------------------------------
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    always_comb begin
        hex_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (blank_q[k] || lz_mask[k] || blink_dark[k]) begin
                hex_d[7*k +: 7] = GLYPH_BLANK;
            end else begin
                hex_d[7*k +: 7] = hex_glyph(value_q[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hex_q <= '1;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign HEX = hex_q;

endmodule
